// File: rtl/rob_wb_tracker_pkg.sv
// Shared widths and the reorder-buffer entry layout used by the tracker and its bench.
package rob_wb_tracker_pkg;

  localparam int REGISTER_WIDTH = 5;
  localparam int DATA_WIDTH     = 32;
  localparam int ROB_DEPTH      = 8;

  typedef struct packed {
    logic                      valid;
    logic                      done;
    logic                      reg_wr_en;
    logic [REGISTER_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     data;
  } rob_entry_t;

endpackage

// File: rtl/rob_wb_tracker_if.sv
// Allocation, writeback and commit signals of the reorder buffer; suffixes are from the tracker's view.
interface rob_wb_tracker_if #(
  parameter int REGISTER_WIDTH = rob_wb_tracker_pkg::REGISTER_WIDTH,
  parameter int DATA_WIDTH     = rob_wb_tracker_pkg::DATA_WIDTH,
  parameter int ROB_IDX_WIDTH  = $clog2(rob_wb_tracker_pkg::ROB_DEPTH)
);
  logic                      alloc_valid_i;
  logic                      alloc_reg_wr_en_i;
  logic [REGISTER_WIDTH-1:0] alloc_rd_i;
  logic [ROB_IDX_WIDTH-1:0]  alloc_idx_o;
  logic                      rob_is_full_o;

  logic                      alu_wb_req_i;
  logic [ROB_IDX_WIDTH-1:0]  alu_wb_idx_i;
  logic [DATA_WIDTH-1:0]     alu_wb_data_i;
  logic                      alu_allowed_wb_o;

  logic                      ex_wb_req_i;
  logic [ROB_IDX_WIDTH-1:0]  ex_wb_idx_i;
  logic [DATA_WIDTH-1:0]     ex_wb_data_i;
  logic                      ex_allowed_wb_o;

  logic                      mem_wb_valid_i;
  logic [ROB_IDX_WIDTH-1:0]  mem_wb_idx_i;
  logic [DATA_WIDTH-1:0]     mem_wb_data_i;

  logic                      commit_valid_o;
  logic                      commit_reg_wr_en_o;
  logic [REGISTER_WIDTH-1:0] commit_rd_o;
  logic [DATA_WIDTH-1:0]     commit_data_o;

  modport slave (
    input  alloc_valid_i, alloc_reg_wr_en_i, alloc_rd_i,
    output alloc_idx_o, rob_is_full_o,
    input  alu_wb_req_i, alu_wb_idx_i, alu_wb_data_i,
    output alu_allowed_wb_o,
    input  ex_wb_req_i, ex_wb_idx_i, ex_wb_data_i,
    output ex_allowed_wb_o,
    input  mem_wb_valid_i, mem_wb_idx_i, mem_wb_data_i,
    output commit_valid_o, commit_reg_wr_en_o, commit_rd_o, commit_data_o
  );

  modport master (
    output alloc_valid_i, alloc_reg_wr_en_i, alloc_rd_i,
    input  alloc_idx_o, rob_is_full_o,
    output alu_wb_req_i, alu_wb_idx_i, alu_wb_data_i,
    input  alu_allowed_wb_o,
    output ex_wb_req_i, ex_wb_idx_i, ex_wb_data_i,
    input  ex_allowed_wb_o,
    output mem_wb_valid_i, mem_wb_idx_i, mem_wb_data_i,
    input  commit_valid_o, commit_reg_wr_en_o, commit_rd_o, commit_data_o
  );
endinterface

// File: rtl/rob_wb_tracker_arbiter.sv
// Shared ALU/EX writeback port: the older instruction (closer to head) wins when both request.
module wb_port_arbiter #(
  parameter int IDX_W = 3
) (
  input  logic [IDX_W-1:0] head_i,
  input  logic             alu_req_i,
  input  logic [IDX_W-1:0] alu_idx_i,
  input  logic             ex_req_i,
  input  logic [IDX_W-1:0] ex_idx_i,
  output logic             alu_grant_o,
  output logic             ex_grant_o
);

  logic [IDX_W-1:0] alu_age;
  logic [IDX_W-1:0] ex_age;

  // Modular subtraction keeps ages correct across pointer wrap.
  assign alu_age = alu_idx_i - head_i;
  assign ex_age  = ex_idx_i - head_i;

  always_comb begin
    alu_grant_o = 1'b0;
    ex_grant_o  = 1'b0;
    if (alu_req_i && ex_req_i) begin
      if (alu_age <= ex_age) alu_grant_o = 1'b1;
      else                   ex_grant_o  = 1'b1;
    end else begin
      alu_grant_o = alu_req_i;
      ex_grant_o  = ex_req_i;
    end
  end

endmodule

// File: rtl/rob_wb_tracker.sv
// In-order reorder buffer: allocate at decode, complete out of order, retire one per cycle.
module rob_wb_tracker #(
  parameter int ROB_DEPTH      = rob_wb_tracker_pkg::ROB_DEPTH,
  parameter int REGISTER_WIDTH = rob_wb_tracker_pkg::REGISTER_WIDTH,
  parameter int DATA_WIDTH     = rob_wb_tracker_pkg::DATA_WIDTH,
  parameter int ROB_IDX_WIDTH  = $clog2(ROB_DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  rob_wb_tracker_if.slave  bus
);

  typedef struct packed {
    logic                      valid;
    logic                      done;
    logic                      reg_wr_en;
    logic [REGISTER_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     data;
  } entry_t;

  localparam logic [ROB_IDX_WIDTH:0]   FullCount = (ROB_IDX_WIDTH+1)'(ROB_DEPTH);
  localparam logic [ROB_IDX_WIDTH:0]   CntOne    = (ROB_IDX_WIDTH+1)'(1);
  localparam logic [ROB_IDX_WIDTH-1:0] IdxOne    = ROB_IDX_WIDTH'(1);

  entry_t                   entries_q [ROB_DEPTH];
  entry_t                   entries_d [ROB_DEPTH];
  logic [ROB_IDX_WIDTH-1:0] head_q, head_d;
  logic [ROB_IDX_WIDTH-1:0] tail_q, tail_d;
  logic [ROB_IDX_WIDTH:0]   count_q, count_d;

  logic full;
  logic alloc_fire;
  logic commit_fire;
  logic alu_grant;
  logic ex_grant;

  wb_port_arbiter #(.IDX_W(ROB_IDX_WIDTH)) u_arb (
    .head_i      (head_q),
    .alu_req_i   (bus.alu_wb_req_i),
    .alu_idx_i   (bus.alu_wb_idx_i),
    .ex_req_i    (bus.ex_wb_req_i),
    .ex_idx_i    (bus.ex_wb_idx_i),
    .alu_grant_o (alu_grant),
    .ex_grant_o  (ex_grant)
  );

  // Full comes from registered count, so a same-cycle commit never admits an allocation.
  assign full        = (count_q == FullCount);
  assign alloc_fire  = bus.alloc_valid_i && !full;
  assign commit_fire = !flush_i && entries_q[head_q].valid && entries_q[head_q].done;

  assign bus.alloc_idx_o        = tail_q;
  assign bus.rob_is_full_o      = full;
  assign bus.alu_allowed_wb_o   = alu_grant;
  assign bus.ex_allowed_wb_o    = ex_grant;
  assign bus.commit_valid_o     = commit_fire;
  assign bus.commit_reg_wr_en_o = entries_q[head_q].reg_wr_en;
  assign bus.commit_rd_o        = entries_q[head_q].rd;
  assign bus.commit_data_o      = entries_q[head_q].data;

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (flush_i) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entries_d[i].valid = 1'b0;
        entries_d[i].done  = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (alu_grant && entries_q[bus.alu_wb_idx_i].valid) begin
        entries_d[bus.alu_wb_idx_i].done = 1'b1;
        entries_d[bus.alu_wb_idx_i].data = bus.alu_wb_data_i;
      end
      if (ex_grant && entries_q[bus.ex_wb_idx_i].valid) begin
        entries_d[bus.ex_wb_idx_i].done = 1'b1;
        entries_d[bus.ex_wb_idx_i].data = bus.ex_wb_data_i;
      end
      if (bus.mem_wb_valid_i && entries_q[bus.mem_wb_idx_i].valid) begin
        entries_d[bus.mem_wb_idx_i].done = 1'b1;
        entries_d[bus.mem_wb_idx_i].data = bus.mem_wb_data_i;
      end
      if (commit_fire) begin
        entries_d[head_q].valid = 1'b0;
        entries_d[head_q].done  = 1'b0;
        head_d = head_q + IdxOne;
      end
      if (alloc_fire) begin
        entries_d[tail_q].valid     = 1'b1;
        entries_d[tail_q].done      = 1'b0;
        entries_d[tail_q].reg_wr_en = bus.alloc_reg_wr_en_i;
        entries_d[tail_q].rd        = bus.alloc_rd_i;
        tail_d = tail_q + IdxOne;
      end
      case ({alloc_fire, commit_fire})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ROB_DEPTH; i++) entries_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_rob_wb_tracker.sv
// Directed bench for rob_wb_tracker with a commit-order scoreboard and a small reference model.
module tb_rob_wb_tracker;
  import rob_wb_tracker_pkg::*;

  typedef struct {
    logic [REGISTER_WIDTH-1:0] rd;
    logic                      wr;
    int                        tag;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   checks   = 0;
  int   failures = 0;

  rob_entry_t m_ent [ROB_DEPTH];
  int         m_head, m_tail, m_cnt;
  sb_t        sb_q [$];

  rob_wb_tracker_if bus ();

  rob_wb_tracker dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ROB_DEPTH; i++) m_ent[i] = '0;
    m_head = 0;
    m_tail = 0;
    m_cnt  = 0;
    sb_q.delete();
  endtask

  task automatic idle_inputs();
    bus.alloc_valid_i     = 1'b0;
    bus.alloc_reg_wr_en_i = 1'b0;
    bus.alloc_rd_i        = '0;
    bus.alu_wb_req_i      = 1'b0;
    bus.alu_wb_idx_i      = '0;
    bus.alu_wb_data_i     = '0;
    bus.ex_wb_req_i       = 1'b0;
    bus.ex_wb_idx_i       = '0;
    bus.ex_wb_data_i      = '0;
    bus.mem_wb_valid_i    = 1'b0;
    bus.mem_wb_idx_i      = '0;
    bus.mem_wb_data_i     = '0;
    flush                 = 1'b0;
  endtask

  // Checks outputs for the current cycle against the model, then advances model and DUT one edge.
  task automatic step();
    logic exp_cv, ga, ge;
    int   aa, ea, hd;
    sb_t  e;
    #1;
    hd     = m_head;
    exp_cv = !flush && m_ent[hd].valid && m_ent[hd].done;
    aa     = (int'(bus.alu_wb_idx_i) - hd + ROB_DEPTH) % ROB_DEPTH;
    ea     = (int'(bus.ex_wb_idx_i) - hd + ROB_DEPTH) % ROB_DEPTH;
    ga     = bus.alu_wb_req_i && (!bus.ex_wb_req_i || aa <= ea);
    ge     = bus.ex_wb_req_i && (!bus.alu_wb_req_i || ea < aa);
    chk("commit_valid", bus.commit_valid_o, exp_cv);
    chk("rob_full", bus.rob_is_full_o, m_cnt == ROB_DEPTH);
    chk("alloc_idx", bus.alloc_idx_o, m_tail);
    chk("alu_grant", bus.alu_allowed_wb_o, ga);
    chk("ex_grant", bus.ex_allowed_wb_o, ge);
    if (exp_cv) begin
      chk("sb_nonempty", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("commit_tag_order", hd, e.tag);
        chk("commit_rd", bus.commit_rd_o, e.rd);
        chk("commit_wr_en", bus.commit_reg_wr_en_o, e.wr);
        chk("commit_data", bus.commit_data_o, m_ent[hd].data);
      end
    end
    if (flush) begin
      model_reset();
    end else begin
      if (ga && m_ent[bus.alu_wb_idx_i].valid) begin
        m_ent[bus.alu_wb_idx_i].done = 1'b1;
        m_ent[bus.alu_wb_idx_i].data = bus.alu_wb_data_i;
      end
      if (ge && m_ent[bus.ex_wb_idx_i].valid) begin
        m_ent[bus.ex_wb_idx_i].done = 1'b1;
        m_ent[bus.ex_wb_idx_i].data = bus.ex_wb_data_i;
      end
      if (bus.mem_wb_valid_i && m_ent[bus.mem_wb_idx_i].valid) begin
        m_ent[bus.mem_wb_idx_i].done = 1'b1;
        m_ent[bus.mem_wb_idx_i].data = bus.mem_wb_data_i;
      end
      if (exp_cv) begin
        m_ent[hd].valid = 1'b0;
        m_ent[hd].done  = 1'b0;
        m_head = (m_head + 1) % ROB_DEPTH;
        m_cnt--;
      end
      if (bus.alloc_valid_i && !(m_cnt == ROB_DEPTH || (exp_cv && m_cnt == ROB_DEPTH - 1))) begin
        m_ent[m_tail].valid     = 1'b1;
        m_ent[m_tail].done      = 1'b0;
        m_ent[m_tail].reg_wr_en = bus.alloc_reg_wr_en_i;
        m_ent[m_tail].rd        = bus.alloc_rd_i;
        sb_q.push_back('{rd: bus.alloc_rd_i, wr: bus.alloc_reg_wr_en_i, tag: m_tail});
        m_tail = (m_tail + 1) % ROB_DEPTH;
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input int rd, input logic wr);
    bus.alloc_valid_i     = 1'b1;
    bus.alloc_rd_i        = REGISTER_WIDTH'(rd);
    bus.alloc_reg_wr_en_i = wr;
    step();
    bus.alloc_valid_i     = 1'b0;
  endtask

  task automatic do_mem(input int tag, input logic [31:0] data);
    bus.mem_wb_valid_i = 1'b1;
    bus.mem_wb_idx_i   = 3'(tag);
    bus.mem_wb_data_i  = data;
    step();
    bus.mem_wb_valid_i = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    #3;
    chk("reset_full", bus.rob_is_full_o, 1'b0);
    chk("reset_commit_valid", bus.commit_valid_o, 1'b0);
    chk("reset_alloc_idx", bus.alloc_idx_o, 0);
    chk("reset_alu_grant", bus.alu_allowed_wb_o, 1'b0);
    chk("reset_ex_grant", bus.ex_allowed_wb_o, 1'b0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill to capacity, then an ignored ninth allocation.
    for (int i = 0; i < 8; i++) do_alloc(i + 1, 1'b1);
    chk("full_after_8", bus.rob_is_full_o, 1'b1);
    do_alloc(20, 1'b1);
    chk("ninth_tail", bus.alloc_idx_o, 0);
    chk("ninth_full", bus.rob_is_full_o, 1'b1);
    do_flush();
    chk("post_flush_full", bus.rob_is_full_o, 1'b0);

    // Out-of-order completion, in-order retirement.
    do_alloc(3, 1'b1);
    do_alloc(4, 1'b0);
    do_alloc(5, 1'b1);
    do_mem(2, 32'hCAFE_0002);
    bus.alu_wb_req_i  = 1'b1;
    bus.alu_wb_idx_i  = 3'd0;
    bus.alu_wb_data_i = 32'hA1A1_0000;
    step();
    bus.alu_wb_req_i = 1'b0;
    chk("ooo_commit0", bus.commit_valid_o, 1'b1);
    chk("ooo_commit0_rd", bus.commit_rd_o, 3);
    step();
    chk("ooo_stall", bus.commit_valid_o, 1'b0);
    step();
    bus.ex_wb_req_i  = 1'b1;
    bus.ex_wb_idx_i  = 3'd1;
    bus.ex_wb_data_i = 32'hE0E0_0001;
    step();
    bus.ex_wb_req_i = 1'b0;
    chk("ooo_commit1_data", bus.commit_data_o, 32'hE0E0_0001);
    step();
    chk("ooo_commit2_data", bus.commit_data_o, 32'hCAFE_0002);
    step();
    step();

    // Move head to 6, then check the age compare across the wrap.
    for (int i = 0; i < 3; i++) do_alloc(10 + i, 1'b1);
    for (int i = 3; i < 6; i++) do_mem(i, 32'h1000 + i);
    for (int i = 0; i < 3; i++) step();
    for (int i = 0; i < 3; i++) do_alloc(16 + i, 1'b1);
    bus.alu_wb_req_i  = 1'b1;
    bus.alu_wb_idx_i  = 3'd7;
    bus.alu_wb_data_i = 32'h7777_0007;
    bus.ex_wb_req_i   = 1'b1;
    bus.ex_wb_idx_i   = 3'd0;
    bus.ex_wb_data_i  = 32'hEEEE_0000;
    #1;
    chk("wrap_alu_wins", bus.alu_allowed_wb_o, 1'b1);
    chk("wrap_ex_loses", bus.ex_allowed_wb_o, 1'b0);
    step();
    bus.alu_wb_req_i = 1'b0;
    #1;
    chk("wrap_ex_alone", bus.ex_allowed_wb_o, 1'b1);
    step();
    bus.ex_wb_req_i = 1'b0;
    do_mem(6, 32'h6666_0006);
    for (int i = 0; i < 4; i++) step();

    // Full ROB: same-cycle commit frees a slot but the allocation is still rejected.
    for (int i = 0; i < 8; i++) do_alloc(i + 8, 1'b1);
    do_mem(1, 32'hF011_0001);
    chk("full_head_done", bus.commit_valid_o, 1'b1);
    do_alloc(30, 1'b1);
    chk("full_commit_not_full", bus.rob_is_full_o, 1'b0);
    chk("full_alloc_rejected_tail", bus.alloc_idx_o, 1);
    do_alloc(31, 1'b0);
    chk("refill_full", bus.rob_is_full_o, 1'b1);
    do_flush();

    // Flush beats simultaneous alloc and completion.
    for (int i = 0; i < 5; i++) do_alloc(i + 2, 1'b1);
    bus.alu_wb_req_i  = 1'b1;
    bus.alu_wb_idx_i  = 3'd3;
    bus.alu_wb_data_i = 32'h3333_0003;
    bus.mem_wb_valid_i = 1'b1;
    bus.mem_wb_idx_i   = 3'd4;
    bus.mem_wb_data_i  = 32'h4444_0004;
    step();
    idle_inputs();
    flush              = 1'b1;
    bus.alloc_valid_i  = 1'b1;
    bus.alloc_rd_i     = 5'd9;
    bus.mem_wb_valid_i = 1'b1;
    bus.mem_wb_idx_i   = 3'd0;
    bus.mem_wb_data_i  = 32'h0BAD_0000;
    step();
    idle_inputs();
    chk("flush_no_commit", bus.commit_valid_o, 1'b0);
    chk("flush_not_full", bus.rob_is_full_o, 1'b0);
    chk("flush_alloc_idx", bus.alloc_idx_o, 0);
    step();

    // Asynchronous reset between edges.
    do_alloc(7, 1'b1);
    do_alloc(8, 1'b1);
    do_mem(0, 32'h5555_0000);
    chk("pre_rst_commit", bus.commit_valid_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_commit", bus.commit_valid_o, 1'b0);
    chk("async_rst_alloc_idx", bus.alloc_idx_o, 0);
    chk("async_rst_full", bus.rob_is_full_o, 1'b0);
    model_reset();
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_alloc(12, 1'b1);
    do_mem(0, 32'h1234_5678);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
